// File: rtl/mem_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM state encoding, grant codes,
// transfer FIFO entry layout and parameter defaults.
package mem_arb_pkg;

  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPC  = 2'b01,
    ST_TFR  = 2'b10
  } arb_state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_IDLE = 2'b00;
  localparam grant_t GRANT_CPC  = 2'b01;
  localparam grant_t GRANT_TFR  = 2'b10;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
  } tfr_entry_t;

  function automatic grant_t state_to_grant(arb_state_e s);
    case (s)
      ST_CPC:  return GRANT_CPC;
      ST_TFR:  return GRANT_TFR;
      default: return GRANT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tfr_fifo.sv
// Synchronous FIFO holding pending support-CPU writes as {addr, data}.
// Pushes while full are ignored here; the caller flags the overflow.
module tfr_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       memclk_i,
  input  logic       nreset_i,
  input  logic       push,
  input  tfr_entry_t push_data,
  input  logic       pop,
  output tfr_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  tfr_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count define validity,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge memclk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one SDRAM port between CPC accesses and queued support-CPU
// writes, with a starvation counter that lets old transfers outrank the CPC.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        memclk_i,
  input  logic        nreset_i,
  input  logic        tfr_wr_i,
  input  logic [23:0] tfr_A_i,
  input  logic [7:0]  tfr_D_i,
  output logic        tfr_full_o,
  output logic        tfr_empty_o,
  output logic        tfr_ovf_o,
  input  logic        cpc_req_i,
  input  logic        cpc_we_i,
  input  logic [23:0] cpc_A_i,
  input  logic [7:0]  cpc_D_i,
  output logic        cpc_ack_o,
  output logic [7:0]  cpc_D_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [23:0] mem_A_o,
  output logic [7:0]  mem_D_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_D_i,
  output logic [1:0]  grant_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state;
  arb_state_e          state_n;
  logic [STARVE_W-1:0] starve_cnt;
  tfr_entry_t          push_entry;
  tfr_entry_t          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                cpc_eligible;
  logic                starved;
  logic                tfr_pick;
  logic                enter_tfr;
  logic                enter_cpc;
  logic                leave_grant;

  assign push_entry = '{addr: tfr_A_i, data: tfr_D_i};

  tfr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .memclk_i  (memclk_i),
    .nreset_i  (nreset_i),
    .push      (tfr_wr_i),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The CPC request is ignored while its previous ack is still showing.
  assign cpc_eligible = cpc_req_i && !cpc_ack_o;
  assign starved      = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign tfr_pick     = !fifo_empty && (starved || !cpc_eligible);

  // NOTE: state_n is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (tfr_pick)          state_n = ST_TFR;
        else if (cpc_eligible) state_n = ST_CPC;
      end
      ST_CPC, ST_TFR: begin
        if (mem_ack_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign enter_tfr   = (state == ST_IDLE) && (state_n == ST_TFR);
  assign enter_cpc   = (state == ST_IDLE) && (state_n == ST_CPC);
  assign leave_grant = (state != ST_IDLE) && (state_n == ST_IDLE);
  assign fifo_pop    = (state == ST_TFR) && mem_ack_i;

  assign tfr_full_o  = fifo_full;
  assign tfr_empty_o = fifo_empty;
  assign grant_o     = state_to_grant(state);

  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i) state <= ST_IDLE;
    else           state <= state_n;
  end

  // SDRAM-side request fields are latched only on grant entry, so they
  // stay stable for the whole access.
  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_A_o   <= '0;
      mem_D_o   <= '0;
    end else if (enter_tfr) begin
      mem_req_o <= 1'b1;
      mem_we_o  <= 1'b1;
      mem_A_o   <= fifo_head.addr;
      mem_D_o   <= fifo_head.data;
    end else if (enter_cpc) begin
      mem_req_o <= 1'b1;
      mem_we_o  <= cpc_we_i;
      mem_A_o   <= cpc_A_i;
      mem_D_o   <= cpc_D_i;
    end else if (leave_grant) begin
      mem_req_o <= 1'b0;
    end
  end

  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cpc_ack_o <= 1'b0;
      cpc_D_o   <= '0;
    end else begin
      cpc_ack_o <= (state == ST_CPC) && mem_ack_i;
      if ((state == ST_CPC) && mem_ack_i && !mem_we_o) cpc_D_o <= mem_D_i;
    end
  end

  // Counts how long a queued transfer has waited outside TFR; saturates.
  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      starve_cnt <= '0;
    end else if (enter_tfr) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && (state != ST_TFR) && !starved) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge memclk_i or negedge nreset_i) begin
    if (!nreset_i)                  tfr_ovf_o <= 1'b0;
    else if (tfr_wr_i && fifo_full) tfr_ovf_o <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_mem_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        memclk_i;
  logic        nreset_i;
  logic        tfr_wr_i;
  logic [23:0] tfr_A_i;
  logic [7:0]  tfr_D_i;
  logic        tfr_full_o;
  logic        tfr_empty_o;
  logic        tfr_ovf_o;
  logic        cpc_req_i;
  logic        cpc_we_i;
  logic [23:0] cpc_A_i;
  logic [7:0]  cpc_D_i;
  logic        cpc_ack_o;
  logic [7:0]  cpc_D_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [23:0] mem_A_o;
  logic [7:0]  mem_D_o;
  logic        mem_ack_i;
  logic [7:0]  mem_D_i;
  logic [1:0]  grant_o;

  mem_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .memclk_i    (memclk_i),
    .nreset_i    (nreset_i),
    .tfr_wr_i    (tfr_wr_i),
    .tfr_A_i     (tfr_A_i),
    .tfr_D_i     (tfr_D_i),
    .tfr_full_o  (tfr_full_o),
    .tfr_empty_o (tfr_empty_o),
    .tfr_ovf_o   (tfr_ovf_o),
    .cpc_req_i   (cpc_req_i),
    .cpc_we_i    (cpc_we_i),
    .cpc_A_i     (cpc_A_i),
    .cpc_D_i     (cpc_D_i),
    .cpc_ack_o   (cpc_ack_o),
    .cpc_D_o     (cpc_D_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_A_o     (mem_A_o),
    .mem_D_o     (mem_D_o),
    .mem_ack_i   (mem_ack_i),
    .mem_D_i     (mem_D_i),
    .grant_o     (grant_o)
  );

  initial memclk_i = 1'b0;
  always #5 memclk_i = ~memclk_i;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner 0 idle, 1 CPC, 2 transfer; FIFO as a queue.
  int          m_owner;
  bit          m_req;
  bit          m_we;
  logic [23:0] m_a;
  logic [7:0]  m_d;
  bit          m_cack;
  logic [7:0]  m_cd;
  bit          m_ovf;
  int          m_starve;
  logic [31:0] m_q[$];

  task automatic model_reset();
    m_owner = 0; m_req = 0; m_we = 0; m_a = '0; m_d = '0;
    m_cack = 0; m_cd = '0; m_ovf = 0; m_starve = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit full, elig, pick, pop, entering_tfr;
    int next_owner;
    full = (m_q.size() == DEPTH);
    elig = cpc_req_i && !m_cack;
    pick = (m_q.size() > 0) && (m_starve == LIMIT || !elig);
    pop  = (m_owner == 2) && mem_ack_i;
    next_owner = m_owner;
    entering_tfr = 0;
    m_cack = 0;
    if (m_owner == 0) begin
      if (pick) begin
        next_owner = 2; entering_tfr = 1;
        m_req = 1; m_we = 1; m_a = m_q[0][31:8]; m_d = m_q[0][7:0];
      end else if (elig) begin
        next_owner = 1;
        m_req = 1; m_we = cpc_we_i; m_a = cpc_A_i; m_d = cpc_D_i;
      end
    end else if (mem_ack_i) begin
      if (m_owner == 1) begin
        m_cack = 1;
        if (!m_we) m_cd = mem_D_i;
      end
      next_owner = 0;
      m_req = 0;
    end
    if (entering_tfr) m_starve = 0;
    else if (m_q.size() > 0 && m_owner != 2 && m_starve < LIMIT) m_starve++;
    if (tfr_wr_i) begin
      if (full) m_ovf = 1;
      else      m_q.push_back({tfr_A_i, tfr_D_i});
    end
    if (pop) void'(m_q.pop_front());
    m_owner = next_owner;
  endtask

  function automatic logic [47:0] pack_out(logic [1:0] g, logic r, logic w, logic [23:0] a,
                                           logic [7:0] d, logic ca, logic [7:0] cd,
                                           logic f, logic e, logic o);
    return {g, r, w, a, d, ca, cd, f, e, o};
  endfunction

  function automatic logic [47:0] dut_pack();
    return pack_out(grant_o, mem_req_o, mem_we_o, mem_A_o, mem_D_o, cpc_ack_o, cpc_D_o,
                    tfr_full_o, tfr_empty_o, tfr_ovf_o);
  endfunction

  function automatic logic [47:0] model_pack();
    return pack_out(2'(m_owner), m_req, m_we, m_a, m_d, m_cack, m_cd,
                    m_q.size() == DEPTH, m_q.size() == 0, m_ovf);
  endfunction

  task automatic tick(input string tag);
    model_step();
    @(posedge memclk_i);
    #1;
    check(tag, 64'(dut_pack()), 64'(model_pack()));
  endtask

  task automatic drive_idle();
    tfr_wr_i = 0; tfr_A_i = '0; tfr_D_i = '0;
    cpc_req_i = 0; cpc_we_i = 0; cpc_A_i = '0; cpc_D_i = '0;
    mem_ack_i = 0; mem_D_i = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    nreset_i = 0;
    model_reset();
    @(negedge memclk_i);
    @(negedge memclk_i);
    check("reset_state", 64'(dut_pack()),
          64'(pack_out(2'b00, 0, 0, '0, '0, 0, '0, 0, 1, 0)));
    nreset_i = 1;
  endtask

  typedef struct {
    bit          push;
    logic [23:0] a;
    logic [7:0]  d;
    bit          ack;
    bit          full;
    bit          empty;
    bit          ovf;
    logic [1:0]  grant;
    logic [23:0] ma;
    logic [7:0]  md;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bit pushed;
    int push_pct;

    // Fill to overflow, drain in order, and push+pop at occupancy 2.
    vecs[0]  = '{1, 24'h000100, 8'h10, 0, 0, 0, 0, 2'b00, 24'h000000, 8'h00};
    vecs[1]  = '{1, 24'h000101, 8'h11, 0, 0, 0, 0, 2'b10, 24'h000100, 8'h10};
    vecs[2]  = '{1, 24'h000102, 8'h12, 0, 0, 0, 0, 2'b10, 24'h000100, 8'h10};
    vecs[3]  = '{1, 24'h000103, 8'h13, 0, 1, 0, 0, 2'b10, 24'h000100, 8'h10};
    vecs[4]  = '{1, 24'h000104, 8'h14, 0, 1, 0, 1, 2'b10, 24'h000100, 8'h10};
    vecs[5]  = '{0, 24'h000000, 8'h00, 1, 0, 0, 1, 2'b00, 24'h000100, 8'h10};
    vecs[6]  = '{0, 24'h000000, 8'h00, 0, 0, 0, 1, 2'b10, 24'h000101, 8'h11};
    vecs[7]  = '{0, 24'h000000, 8'h00, 1, 0, 0, 1, 2'b00, 24'h000101, 8'h11};
    vecs[8]  = '{0, 24'h000000, 8'h00, 0, 0, 0, 1, 2'b10, 24'h000102, 8'h12};
    vecs[9]  = '{1, 24'h000105, 8'h15, 1, 0, 0, 1, 2'b00, 24'h000102, 8'h12};
    vecs[10] = '{0, 24'h000000, 8'h00, 0, 0, 0, 1, 2'b10, 24'h000103, 8'h13};
    vecs[11] = '{0, 24'h000000, 8'h00, 1, 0, 0, 1, 2'b00, 24'h000103, 8'h13};
    vecs[12] = '{0, 24'h000000, 8'h00, 0, 0, 0, 1, 2'b10, 24'h000105, 8'h15};
    vecs[13] = '{0, 24'h000000, 8'h00, 1, 0, 1, 1, 2'b00, 24'h000105, 8'h15};
    vecs[14] = '{0, 24'h000000, 8'h00, 0, 0, 1, 1, 2'b00, 24'h000105, 8'h15};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      tfr_wr_i  = vecs[i].push;
      tfr_A_i   = vecs[i].a;
      tfr_D_i   = vecs[i].d;
      mem_ack_i = vecs[i].ack;
      tick($sformatf("vec%0d_model", i));
      check($sformatf("vec%0d", i),
            64'({tfr_full_o, tfr_empty_o, tfr_ovf_o, grant_o, mem_A_o, mem_D_o}),
            64'({vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].grant, vecs[i].ma, vecs[i].md}));
    end
    drive_idle();

    // Single transfer, ack three cycles after the request rises.
    do_reset();
    tfr_wr_i = 1; tfr_A_i = 24'h001234; tfr_D_i = 8'h5A;
    tick("t041_push");
    drive_idle();
    for (int i = 0; i < 10 && !mem_req_o; i++) tick("t041_wait");
    check("t041_req", 64'(mem_req_o), 64'(1));
    check("t041_fields", 64'({mem_we_o, mem_A_o, mem_D_o, grant_o}),
          64'({1'b1, 24'h001234, 8'h5A, 2'b10}));
    tick("t041_hold1");
    tick("t041_hold2");
    check("t041_stable", 64'({mem_req_o, mem_we_o, mem_A_o, mem_D_o}),
          64'({1'b1, 1'b1, 24'h001234, 8'h5A}));
    mem_ack_i = 1;
    tick("t041_ack");
    mem_ack_i = 0;
    check("t041_done", 64'({mem_req_o, tfr_empty_o, grant_o}), 64'({1'b0, 1'b1, 2'b00}));

    // CPC read.
    cpc_req_i = 1; cpc_we_i = 0; cpc_A_i = 24'h00C000; cpc_D_i = 8'h00;
    tick("t042_req");
    check("t042_grant", 64'({grant_o, mem_req_o, mem_we_o, mem_A_o}),
          64'({2'b01, 1'b1, 1'b0, 24'h00C000}));
    mem_ack_i = 1; mem_D_i = 8'hA5;
    tick("t042_ack");
    check("t042_pulse", 64'({cpc_ack_o, cpc_D_o, grant_o}), 64'({1'b1, 8'hA5, 2'b00}));
    drive_idle();
    tick("t042_after");
    check("t042_hold", 64'({cpc_ack_o, cpc_D_o, grant_o}), 64'({1'b0, 8'hA5, 2'b00}));

    // CPC held continuously; a queued transfer must not wait past the limit.
    do_reset();
    cpc_req_i = 1; cpc_we_i = 1; cpc_A_i = 24'h00ABCD; cpc_D_i = 8'h77;
    waited = 0; pushed = 0;
    for (int i = 0; i < 60; i++) begin
      mem_ack_i = mem_req_o;
      tfr_wr_i = (i == 3);
      tfr_A_i = 24'h00BEEF; tfr_D_i = 8'h3C;
      tick("t043_cycle");
      if (i == 3) pushed = 1;
      else if (pushed) waited++;
      if (pushed && grant_o == 2'b10) break;
    end
    tfr_wr_i = 0;
    check("t043_granted", 64'(grant_o), 64'(2'b10));
    check("t043_bound", 64'(waited <= LIMIT), 64'(1));
    cpc_req_i = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack_i = mem_req_o;
      tick("t043_drain");
    end
    mem_ack_i = 0;

    // Reset while a transfer is outstanding.
    do_reset();
    tfr_wr_i = 1; tfr_A_i = 24'h000777; tfr_D_i = 8'h99;
    tick("t046_push");
    tfr_wr_i = 0;
    for (int i = 0; i < 10 && !mem_req_o; i++) tick("t046_wait");
    check("t046_busy", 64'({mem_req_o, grant_o}), 64'({1'b1, 2'b10}));
    #2;
    nreset_i = 0;
    #1;
    check("t046_reset", 64'({mem_req_o, tfr_empty_o, tfr_full_o, grant_o}),
          64'({1'b0, 1'b1, 1'b0, 2'b00}));
    model_reset();
    @(negedge memclk_i);
    nreset_i = 1;
    tick("t046_after");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      push_pct = ((i / 400) % 2 == 0) ? 15 : 70;
      tfr_wr_i = ($urandom_range(0, 99) < push_pct);
      tfr_A_i  = 24'($urandom);
      tfr_D_i  = 8'($urandom);
      if (cpc_ack_o) begin
        cpc_req_i = $urandom_range(0, 1) == 1;
        cpc_we_i  = $urandom_range(0, 1) == 1;
        cpc_A_i   = 24'($urandom);
        cpc_D_i   = 8'($urandom);
      end else if (!cpc_req_i && $urandom_range(0, 99) < 25) begin
        cpc_req_i = 1;
        cpc_we_i  = $urandom_range(0, 1) == 1;
        cpc_A_i   = 24'($urandom);
        cpc_D_i   = 8'($urandom);
      end else if (cpc_req_i && $urandom_range(0, 99) < 3) begin
        cpc_req_i = 0;
      end
      mem_ack_i = mem_req_o ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      mem_D_i   = 8'($urandom);
      tick("rand");
    end
    drive_idle();
    tick("rand_end");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
